// File: rtl/core_pkg.sv
// ============================================================================
// Module  : core_pkg
// Purpose : Shared widths, fetch FSM state encodings and fetch stride for the
//           instruction-fetch front end.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  // Byte stride between consecutive fetches, sized to the address so the
  // pc increment needs no width conversion.
  localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage : core_pkg

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ============================================================================
// Module  : ifetch_queue
// Purpose : Small synchronous FIFO holding {pc, instr} entries between the
//           fetch initiator and decode. Flush empties it in one edge.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_push/i_wdata - enqueue request and entry
//           i_pop          - dequeue head (ignored when empty)
//           i_flush        - discard every entry
//           o_rdata        - head entry (undefined when empty)
//           o_full/o_empty/o_count - occupancy status
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full  = (r_count == C_FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A push into a full queue is accepted only when the head leaves on the
  // same edge, so occupancy never exceeds DEPTH.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_do_push && !rst && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule : ifetch_queue

`default_nettype wire

// File: rtl/ifetch_master.sv
// ============================================================================
// Module  : ifetch_master
// Purpose : Instruction-RAM bus initiator. Presents the pc on HADDR, captures
//           HRDATA[31:0] when HREADY, and queues {pc, instr} for decode over
//           valid/ready. Handles redirects and misaligned-pc faults.
// Ports   : HCLK, HRESET           - clock, synchronous active-high reset
//           HADDR/HWDATA/HWRITE    - bus request (read-only initiator)
//           HRDATA/HREADY          - bus response
//           instr_valid/ready/data/pc - decode-side handshake and payload
//           redirect_valid/pc      - branch/jump redirect
//           fetch_fault            - sticky misaligned-pc indication
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_master
  import core_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 64'h0,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic                HCLK,
  input  logic                HRESET,
  output logic [ADDR_W-1:0]   HADDR,
  output logic [63:0]         HWDATA,
  output logic                HWRITE,
  input  logic [63:0]         HRDATA,
  input  logic                HREADY,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr_data,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                fetch_fault
);

  localparam int C_ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_t                   r_state;
  logic [ADDR_W-1:0]              r_pc;
  logic                           r_fault;

  logic                           w_pop;
  logic                           w_push;
  logic                           w_full;
  logic                           w_empty;
  logic [$clog2(QUEUE_DEPTH):0]   w_count;
  logic [C_ENTRY_W-1:0]           w_head;
  logic [INSTR_W+$clog2(QUEUE_DEPTH):0] w_unused_bits;

  assign HADDR       = r_pc;
  assign HWDATA      = '0;
  assign HWRITE      = 1'b0;
  assign fetch_fault = r_fault;

  assign instr_valid = ~w_empty;
  assign instr_pc    = w_head[C_ENTRY_W-1:INSTR_W];
  assign instr_data  = w_head[INSTR_W-1:0];

  // Upper read-data lane and the occupancy count are not needed here.
  assign w_unused_bits = {HRDATA[63:INSTR_W], w_count};

  // A redirect discards the queue, so neither a pop nor a push may take
  // effect on that edge.
  assign w_pop  = instr_valid & instr_ready & ~redirect_valid;
  assign w_push = (r_state == FETCH) & HREADY & (~w_full | w_pop) & ~redirect_valid;

  ifetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (C_ENTRY_W)
  ) u_queue (
    .clk     (HCLK),
    .rst     (HRESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata ({r_pc, HRDATA[INSTR_W-1:0]}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pc    <= RESET_PC;
      r_state <= FETCH;
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        r_state <= FETCH;
        r_fault <= 1'b0;
      end else begin
        r_state <= FAULT;
        r_fault <= 1'b1;
      end
    end else begin
      case (r_state)
        FETCH: begin
          // Wait states freeze everything; a completed beat that cannot be
          // queued (full, no pop) parks the pc and stalls.
          if (HREADY) begin
            if (w_push) r_pc <= r_pc + INSTR_BYTES;
            else        r_state <= STALL;
          end
        end
        STALL: begin
          if (w_pop) r_state <= FETCH;
        end
        FAULT: begin
          r_state <= FAULT;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule : ifetch_master

`default_nettype wire

// File: tb/tb_ifetch_master.sv
// ============================================================================
// Module  : tb_ifetch_master
// Purpose : Directed self-checking bench for ifetch_master with a small
//           combinational instruction-RAM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_master;

  logic        HCLK;
  logic        HRESET;
  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic        HWRITE;
  logic [63:0] HRDATA;
  logic        HREADY;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  ifetch_master #(
    .RESET_PC    (64'h0),
    .QUEUE_DEPTH (2)
  ) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .HADDR          (HADDR),
    .HWDATA         (HWDATA),
    .HWRITE         (HWRITE),
    .HRDATA         (HRDATA),
    .HREADY         (HREADY),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] iram(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h0180_3083;
      64'h4:   return 32'h0010_8093;
      64'h8:   return 32'h0010_8113;
      64'hC:   return 32'h0011_0133;
      default: return 32'h0000_0013;
    endcase
  endfunction

  // Upper lane filled with junk so any use of it would show.
  always_comb HRDATA = {32'hA5A5_A5A5, iram(HADDR)};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic reset_dut();
    HRESET = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  logic [63:0] exp_pc   [4];
  logic [31:0] exp_data [4];

  initial begin
    exp_pc[0] = 64'h0; exp_data[0] = 32'h0180_3083;
    exp_pc[1] = 64'h4; exp_data[1] = 32'h0010_8093;
    exp_pc[2] = 64'h8; exp_data[2] = 32'h0010_8113;
    exp_pc[3] = 64'hC; exp_data[3] = 32'h0011_0133;

    HRESET = 1'b1; HREADY = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state, then streaming at one instruction per cycle.
    tick(); tick();
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_haddr", HADDR, 64'h0);
    check("rst_fault", 64'(fetch_fault), 64'd0);
    check("rst_hwrite", 64'(HWRITE), 64'd0);
    check("rst_hwdata", HWDATA, 64'h0);
    HRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_valid", 64'(instr_valid), 64'd1);
      check("stream_pc", instr_pc, exp_pc[i]);
      check("stream_data", 64'(instr_data), 64'(exp_data[i]));
      check("stream_hwrite", 64'(HWRITE), 64'd0);
    end

    // Backpressure from reset: queue fills with 0,4 and HADDR parks at 8.
    instr_ready = 1'b0;
    reset_dut();
    tick(); tick(); tick();
    check("bp_haddr", HADDR, 64'h8);
    check("bp_head", instr_pc, 64'h0);
    tick();
    check("bp_haddr_hold", HADDR, 64'h8);
    check("bp_head_hold", instr_pc, 64'h0);
    instr_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("bp_drain_valid", 64'(instr_valid), 64'd1);
      check("bp_drain_pc", instr_pc, exp_pc[i]);
    end

    // Redirect to 0xC with a full queue.
    instr_ready = 1'b0;
    reset_dut();
    tick(); tick(); tick();
    check("rd_full_valid", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    redirect(64'hC);
    check("rd_flush_valid", 64'(instr_valid), 64'd0);
    check("rd_haddr", HADDR, 64'hC);
    tick();
    check("rd_valid", 64'(instr_valid), 64'd1);
    check("rd_pc", instr_pc, 64'hC);
    check("rd_data", 64'(instr_data), 64'h0011_0133);
    tick();
    check("rd_next_pc", instr_pc, 64'h10);
    check("rd_next_data", 64'(instr_data), 64'h0000_0013);

    // Misaligned redirect, then recovery.
    redirect(64'h6);
    check("flt_fault", 64'(fetch_fault), 64'd1);
    check("flt_haddr", HADDR, 64'h6);
    check("flt_valid", 64'(instr_valid), 64'd0);
    tick();
    check("flt_fault_hold", 64'(fetch_fault), 64'd1);
    check("flt_haddr_hold", HADDR, 64'h6);
    check("flt_no_push", 64'(instr_valid), 64'd0);
    redirect(64'h0);
    check("flt_clear", 64'(fetch_fault), 64'd0);
    check("flt_clr_haddr", HADDR, 64'h0);
    tick();
    check("flt_resume_valid", 64'(instr_valid), 64'd1);
    check("flt_resume_pc", instr_pc, 64'h0);
    check("flt_resume_data", 64'(instr_data), 64'h0180_3083);

    // HREADY pattern 1,0,0,1 yields exactly two pushes.
    instr_ready = 1'b0; HREADY = 1'b1;
    reset_dut();
    tick();
    check("wait_haddr_c1", HADDR, 64'h4);
    HREADY = 1'b0;
    tick();
    check("wait_haddr_c2", HADDR, 64'h4);
    tick();
    check("wait_haddr_c3", HADDR, 64'h4);
    HREADY = 1'b1;
    tick();
    check("wait_haddr_c4", HADDR, 64'h8);
    check("wait_head0", instr_pc, 64'h0);
    HREADY = 1'b0; instr_ready = 1'b1;
    tick();
    check("wait_head1_valid", 64'(instr_valid), 64'd1);
    check("wait_head1", instr_pc, 64'h4);
    tick();
    check("wait_drained", 64'(instr_valid), 64'd0);

    // Mid-stream reset with a full queue, and reset clearing a fault.
    HREADY = 1'b1; instr_ready = 1'b0;
    reset_dut();
    tick(); tick(); tick();
    check("mrst_pre_valid", 64'(instr_valid), 64'd1);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    check("mrst_valid", 64'(instr_valid), 64'd0);
    check("mrst_haddr", HADDR, 64'h0);
    check("mrst_fault", 64'(fetch_fault), 64'd0);
    redirect(64'h2);
    check("mrst_flt_set", 64'(fetch_fault), 64'd1);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    check("mrst_flt_clr", 64'(fetch_fault), 64'd0);
    check("mrst_flt_haddr", HADDR, 64'h0);

    // pc wraps modulo 2^64.
    instr_ready = 1'b1;
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_haddr_top", HADDR, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_head_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_haddr", HADDR, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ifetch_master

`default_nettype wire
